// File: rtl/hpi_target_model.sv
`default_nettype none
// ============================================================================
// Module   : hpi_target_model
// Brief    : HPI responder (DATA/MAILBOX/ADDRESS/STATUS) backed by 16-bit RAM.
//            Define HPI_TARGET_IRQ_EN to drive hpi_int from STATUS[0].
// Revision : 1.0 - initial release
// ============================================================================
module hpi_target_model #(
  parameter int          RAM_AW       = 8,
  parameter logic [15:0] RESET_STATUS = 16'h0000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  hpi_address,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic [15:0] dev_mbx_rdata,
  output logic        dev_mbx_valid,
  input  logic        dev_mbx_ack,
  input  logic [15:0] dev_mbx_wdata,
  input  logic        dev_mbx_post,
  output logic        hpi_int
);

  localparam logic [1:0] C_REG_DATA = 2'd0;
  localparam logic [1:0] C_REG_MBX  = 2'd1;
  localparam logic [1:0] C_REG_ADDR = 2'd2;
  localparam logic [1:0] C_REG_STAT = 2'd3;

  logic              r_r_n_prev;
  logic              r_w_n_prev;
  logic              r_rd_cs_n;
  logic              r_rd_pend;
  logic [1:0]        r_rd_sel;
  logic [15:0]       r_addr;
  logic [15:0]       r_reg_q;
  logic [15:0]       r_ram_q;
  logic [15:0]       r_data_out;
  logic [15:0]       r_mbx_rdata;
  logic              r_mbx_valid;
  logic [15:0]       r_mbx_to_host;
  logic              r_full;
  logic              r_ovr;
  logic [15:0]       r_ram [0:(1<<RAM_AW)-1];

  logic              w_wr_evt;
  logic              w_wr_data;
  logic              w_rd_start;
  logic              w_rd_end;
  logic              w_rd_end_data;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [15:0]       w_status;
  logic [15:0]       w_reg_snap;
  logic [15:0]       w_addr_nxt;

  // A read strobe that falls while the write strobe is also low is ignored.
  assign w_wr_evt      = !hpi_cs_n && !hpi_w_n && r_w_n_prev;
  assign w_rd_start    = !hpi_cs_n && !hpi_r_n && r_r_n_prev && hpi_w_n;
  assign w_rd_end      = hpi_r_n && !r_r_n_prev;
  assign w_rd_end_data = w_rd_end && !r_rd_cs_n && (r_rd_sel == C_REG_DATA);
  assign w_wr_data     = w_wr_evt && (hpi_address == C_REG_DATA);
  assign w_ram_idx     = r_addr[RAM_AW:1];
  assign w_status      = {6'd0, r_ovr, r_mbx_valid, 7'd0, r_full};

  always_comb begin
    w_reg_snap = r_mbx_to_host;
    case (hpi_address)
      C_REG_ADDR: w_reg_snap = r_addr;
      C_REG_STAT: w_reg_snap = w_status;
      default:    w_reg_snap = r_mbx_to_host;
    endcase
  end

  always_comb begin
    w_addr_nxt = r_addr;
    if (w_wr_evt && (hpi_address == C_REG_ADDR))
      w_addr_nxt = {hpi_data_in[15:1], 1'b0};
    else
      w_addr_nxt = r_addr + (w_wr_data ? 16'd2 : 16'd0) + (w_rd_end_data ? 16'd2 : 16'd0);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset_n && w_wr_data)
      r_ram[w_ram_idx] <= hpi_data_in;
    r_ram_q <= r_ram[w_ram_idx];
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_r_n_prev    <= 1'b1;
      r_w_n_prev    <= 1'b1;
      r_rd_cs_n     <= 1'b1;
      r_rd_pend     <= 1'b0;
      r_rd_sel      <= C_REG_DATA;
      r_addr        <= 16'd0;
      r_reg_q       <= 16'd0;
      r_data_out    <= 16'd0;
      r_mbx_rdata   <= 16'd0;
      r_mbx_valid   <= 1'b0;
      r_mbx_to_host <= 16'd0;
      r_full        <= RESET_STATUS[0];
      r_ovr         <= RESET_STATUS[9];
    end else begin
      r_r_n_prev <= hpi_r_n;
      r_w_n_prev <= hpi_w_n;
      r_addr     <= w_addr_nxt;
      r_rd_pend  <= w_rd_start;

      // Register values are snapshotted at read-start so a same-cycle post
      // still returns the previous mailbox word.
      if (w_rd_start) begin
        r_rd_sel  <= hpi_address;
        r_rd_cs_n <= hpi_cs_n;
        r_reg_q   <= w_reg_snap;
      end else if (w_rd_end) begin
        r_rd_cs_n <= 1'b1;
      end

      if (r_rd_pend)
        r_data_out <= (r_rd_sel == C_REG_DATA) ? r_ram_q : r_reg_q;

      if (w_wr_evt && (hpi_address == C_REG_MBX)) begin
        r_mbx_rdata <= hpi_data_in;
        r_mbx_valid <= 1'b1;
        if (r_mbx_valid && !dev_mbx_ack)
          r_ovr <= 1'b1;
      end else if (dev_mbx_ack) begin
        r_mbx_valid <= 1'b0;
      end

      if (w_wr_evt && (hpi_address == C_REG_STAT) && hpi_data_in[9])
        r_ovr <= 1'b0;

      if (dev_mbx_post) begin
        r_mbx_to_host <= dev_mbx_wdata;
        r_full        <= 1'b1;
      end else if (w_rd_start && (hpi_address == C_REG_MBX)) begin
        r_full <= 1'b0;
      end
    end
  end

  assign hpi_data_out  = r_data_out;
  assign dev_mbx_rdata = r_mbx_rdata;
  assign dev_mbx_valid = r_mbx_valid;

`ifdef HPI_TARGET_IRQ_EN
  logic r_int;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)
      r_int <= 1'b0;
    else
      r_int <= r_full;
  end

  assign hpi_int = r_int;
`else
  assign hpi_int = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpi_target_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpi_target_model
// Brief    : Scoreboard bench for hpi_target_model host and device accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpi_target_model;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [1:0]  hpi_address = 2'd0;
  logic        hpi_cs_n = 1'b1;
  logic        hpi_r_n = 1'b1;
  logic        hpi_w_n = 1'b1;
  logic [15:0] hpi_data_in = 16'd0;
  logic [15:0] hpi_data_out;
  logic [15:0] dev_mbx_rdata;
  logic        dev_mbx_valid;
  logic        dev_mbx_ack = 1'b0;
  logic [15:0] dev_mbx_wdata = 16'd0;
  logic        dev_mbx_post = 1'b0;
  logic        hpi_int;

`ifdef HPI_TARGET_IRQ_EN
  localparam logic C_IRQ = 1'b1;
`else
  localparam logic C_IRQ = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_ram [0:255];
  logic [15:0] m_addr = 16'd0;
  logic [15:0] got;
  logic [15:0] exp;

  hpi_target_model #(.RAM_AW(8), .RESET_STATUS(16'h0000)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .hpi_address   (hpi_address),
    .hpi_cs_n      (hpi_cs_n),
    .hpi_r_n       (hpi_r_n),
    .hpi_w_n       (hpi_w_n),
    .hpi_data_in   (hpi_data_in),
    .hpi_data_out  (hpi_data_out),
    .dev_mbx_rdata (dev_mbx_rdata),
    .dev_mbx_valid (dev_mbx_valid),
    .dev_mbx_ack   (dev_mbx_ack),
    .dev_mbx_wdata (dev_mbx_wdata),
    .dev_mbx_post  (dev_mbx_post),
    .hpi_int       (hpi_int)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk_clk);
    hpi_address = a; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    @(negedge clk_clk);
    hpi_w_n = 1'b1; hpi_cs_n = 1'b1;
    if (a == 2'd0) begin
      m_ram[m_addr[8:1]] = d;
      m_addr = m_addr + 16'd2;
    end else if (a == 2'd2) begin
      m_addr = {d[15:1], 1'b0};
    end
  endtask

  // Samples hpi_data_out two edges after the read strobe falls.
  task automatic host_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk_clk);
    hpi_address = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
    @(negedge clk_clk);
    @(negedge clk_clk);
    d = hpi_data_out;
    hpi_r_n = 1'b1; hpi_cs_n = 1'b1;
    @(negedge clk_clk);
    if (a == 2'd0) m_addr = m_addr + 16'd2;
  endtask

  task automatic dev_post(input logic [15:0] d);
    @(negedge clk_clk);
    dev_mbx_post = 1'b1; dev_mbx_wdata = d;
    @(negedge clk_clk);
    dev_mbx_post = 1'b0;
    @(negedge clk_clk);
  endtask

  task automatic test_reset;
    checks++; if (hpi_data_out !== 16'd0) begin errors++; $display("FAIL rst_data_out: got %h exp 0000", hpi_data_out); end
    checks++; if (dev_mbx_rdata !== 16'd0) begin errors++; $display("FAIL rst_mbx_rdata: got %h exp 0000", dev_mbx_rdata); end
    checks++; if (dev_mbx_valid !== 1'b0) begin errors++; $display("FAIL rst_mbx_valid: got %b exp 0", dev_mbx_valid); end
    checks++; if (hpi_int !== 1'b0) begin errors++; $display("FAIL rst_int: got %b exp 0", hpi_int); end
    exp_q.push_back(16'h0000);
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rst_status: got %h exp %h", got, exp); end
    exp_q.push_back(16'h0000);
    host_read(2'd2, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rst_address: got %h exp %h", got, exp); end
  endtask

  task automatic test_data;
    host_write(2'd2, 16'h0010);
    host_write(2'd0, 16'hBEEF);
    host_write(2'd0, 16'hCAFE);
    host_write(2'd2, 16'h0010);
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'hCAFE);
    exp_q.push_back(16'h0014);
    for (int i = 0; i < 2; i++) begin
      host_read(2'd0, got); exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL data_rd%0d: got %h exp %h", i, got, exp); end
    end
    host_read(2'd2, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL data_addr: got %h exp %h", got, exp); end
  endtask

  task automatic test_host_mailbox;
    host_write(2'd1, 16'h1234);
    checks++; if (dev_mbx_valid !== 1'b1) begin errors++; $display("FAIL mbx_valid1: got %b exp 1", dev_mbx_valid); end
    checks++; if (dev_mbx_rdata !== 16'h1234) begin errors++; $display("FAIL mbx_rdata1: got %h exp 1234", dev_mbx_rdata); end
    exp_q.push_back(16'h0100);
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL mbx_stat1: got %h exp %h", got, exp); end
    host_write(2'd1, 16'h5678);
    checks++; if (dev_mbx_rdata !== 16'h5678) begin errors++; $display("FAIL mbx_rdata2: got %h exp 5678", dev_mbx_rdata); end
    exp_q.push_back(16'h0300);
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL mbx_overrun: got %h exp %h", got, exp); end
    host_write(2'd3, 16'h0200);
    exp_q.push_back(16'h0100);
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL mbx_ovr_clr: got %h exp %h", got, exp); end
    @(negedge clk_clk); dev_mbx_ack = 1'b1;
    @(negedge clk_clk); dev_mbx_ack = 1'b0;
    checks++; if (dev_mbx_valid !== 1'b0) begin errors++; $display("FAIL mbx_ack_valid: got %b exp 0", dev_mbx_valid); end
    exp_q.push_back(16'h0000);
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL mbx_ack_stat: got %h exp %h", got, exp); end
    // Host write coinciding with device ack: the write wins, no overrun.
    host_write(2'd1, 16'h1111);
    @(negedge clk_clk);
    hpi_address = 2'd1; hpi_data_in = 16'h2222; hpi_cs_n = 1'b0; hpi_w_n = 1'b0; dev_mbx_ack = 1'b1;
    @(negedge clk_clk);
    hpi_w_n = 1'b1; hpi_cs_n = 1'b1; dev_mbx_ack = 1'b0;
    checks++; if (dev_mbx_valid !== 1'b1) begin errors++; $display("FAIL mbx_wr_ack_valid: got %b exp 1", dev_mbx_valid); end
    exp_q.push_back(16'h0100);
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL mbx_wr_ack_stat: got %h exp %h", got, exp); end
    @(negedge clk_clk); dev_mbx_ack = 1'b1;
    @(negedge clk_clk); dev_mbx_ack = 1'b0;
  endtask

  task automatic test_dev_mailbox;
    dev_post(16'hA5A5);
    checks++; if (hpi_int !== C_IRQ) begin errors++; $display("FAIL post_int: got %b exp %b", hpi_int, C_IRQ); end
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h0000);
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL post_stat: got %h exp %h", got, exp); end
    host_read(2'd1, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL post_rd: got %h exp %h", got, exp); end
    checks++; if (hpi_int !== 1'b0) begin errors++; $display("FAIL post_int_clr: got %b exp 0", hpi_int); end
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL post_stat_clr: got %h exp %h", got, exp); end
    // Read-start coinciding with a new post returns the old word.
    dev_post(16'hB0B0);
    exp_q.push_back(16'hB0B0);
    @(negedge clk_clk);
    hpi_address = 2'd1; hpi_cs_n = 1'b0; hpi_r_n = 1'b0; dev_mbx_post = 1'b1; dev_mbx_wdata = 16'hC0C0;
    @(negedge clk_clk);
    dev_mbx_post = 1'b0;
    @(negedge clk_clk);
    got = hpi_data_out; hpi_r_n = 1'b1; hpi_cs_n = 1'b1;
    @(negedge clk_clk);
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL race_rd: got %h exp %h", got, exp); end
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'hC0C0);
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL race_stat: got %h exp %h", got, exp); end
    host_read(2'd1, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL race_rd2: got %h exp %h", got, exp); end
  endtask

  task automatic test_wrap;
    host_write(2'd2, 16'hFFFE);
    host_write(2'd0, 16'h1357);
    exp_q.push_back(m_addr);
    host_read(2'd2, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL wrap_addr: got %h exp %h", got, exp); end
    host_write(2'd2, 16'h01FE);
    exp_q.push_back(m_ram[m_addr[8:1]]);
    host_read(2'd0, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL wrap_alias: got %h exp %h", got, exp); end
  endtask

  task automatic test_illegal_and_cs;
    host_write(2'd2, 16'h0022);
    exp_q.push_back(16'h0022);
    host_read(2'd2, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL ill_pre: got %h exp %h", got, exp); end
    @(negedge clk_clk);
    hpi_address = 2'd2; hpi_data_in = 16'h0040; hpi_cs_n = 1'b0; hpi_w_n = 1'b0; hpi_r_n = 1'b0;
    @(negedge clk_clk);
    @(negedge clk_clk);
    checks++; if (hpi_data_out !== 16'h0022) begin errors++; $display("FAIL ill_dout: got %h exp 0022", hpi_data_out); end
    hpi_w_n = 1'b1; hpi_r_n = 1'b1; hpi_cs_n = 1'b1;
    m_addr = 16'h0040;
    @(negedge clk_clk);
    @(negedge clk_clk);
    // Strobes with chip select high must leave every register alone.
    hpi_address = 2'd2; hpi_data_in = 16'h0999; hpi_w_n = 1'b0;
    @(negedge clk_clk); hpi_w_n = 1'b1;
    @(negedge clk_clk);
    hpi_address = 2'd1; hpi_data_in = 16'h3333; hpi_w_n = 1'b0;
    @(negedge clk_clk); hpi_w_n = 1'b1;
    @(negedge clk_clk);
    hpi_address = 2'd0; hpi_w_n = 1'b0;
    @(negedge clk_clk); hpi_w_n = 1'b1;
    checks++; if (dev_mbx_valid !== 1'b0) begin errors++; $display("FAIL cs_mbx_valid: got %b exp 0", dev_mbx_valid); end
    exp_q.push_back(m_addr);
    host_read(2'd2, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL ill_cs_addr: got %h exp %h", got, exp); end
  endtask

  task automatic test_reset_mid_read;
    host_write(2'd2, 16'h0030);
    host_write(2'd1, 16'h7777);
    exp_q.push_back(16'h0030);
    host_read(2'd2, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL mid_pre: got %h exp %h", got, exp); end
    @(negedge clk_clk);
    hpi_address = 2'd0; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b0; hpi_cs_n = 1'b1;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    hpi_r_n = 1'b1;
    @(negedge clk_clk);
    @(negedge clk_clk);
    m_addr = 16'h0000;
    checks++; if (hpi_data_out !== 16'd0) begin errors++; $display("FAIL mid_dout: got %h exp 0000", hpi_data_out); end
    checks++; if (dev_mbx_rdata !== 16'd0) begin errors++; $display("FAIL mid_rdata: got %h exp 0000", dev_mbx_rdata); end
    checks++; if (dev_mbx_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", dev_mbx_valid); end
    checks++; if (hpi_int !== 1'b0) begin errors++; $display("FAIL mid_int: got %b exp 0", hpi_int); end
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    host_read(2'd2, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL mid_addr: got %h exp %h", got, exp); end
    host_read(2'd3, got); exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL mid_stat: got %h exp %h", got, exp); end
  endtask

  initial begin
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    test_reset();
    test_data();
    test_host_mailbox();
    test_dev_mailbox();
    test_wrap();
    test_illegal_and_cs();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
